// File: rtl/snn_pkg.sv
// Shared types for the SNN layer sequencer: FSM states, output modes,
// and a width helper for index fields.
package snn_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      WAIT   = 3'd2,
      SCAN   = 3'd3,
      OUTPUT = 3'd4
   } seq_state_t;

   localparam int MODE_SPIKE  = 0;
   localparam int MODE_COUNT  = 1;
   localparam int MODE_ARGMAX = 2;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spk_fifo.sv
// Synchronous FIFO holding one spike train per entry.
// Ports: i_push/i_data write, i_pop reads head o_data, o_full/o_empty flags.
module spk_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic [AW-1:0]               r_wr;
   logic [AW-1:0]               r_rd;
   logic [AW:0]                 r_count;
   logic                        w_push;
   logic                        w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Time-step sequencer and readout for one SNN layer core.
// Ports: in_* spike-train input, core_* core handshake, out_* result, err_done sticky error.
module snn_layer_sequencer
   import snn_pkg::*;
#(
   parameter int PRE_SYN_LAYER_SIZE = 784,
   parameter int LAYER_SIZE         = 1024,
   parameter int TIME_STEPS         = 4,
   parameter int FIFO_DEPTH         = 4,
   parameter int COUNT_WIDTH        = $clog2(TIME_STEPS + 1),
   parameter int OUT_MODE           = 0,
   localparam int SW                = clog2_min1(TIME_STEPS),
   localparam int CW                = clog2_min1(LAYER_SIZE)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [PRE_SYN_LAYER_SIZE-1:0]     in_spk,
   output logic                              core_start,
   output logic                              core_clear,
   output logic [PRE_SYN_LAYER_SIZE-1:0]     core_spk_in,
   input  logic                              core_done,
   input  logic [LAYER_SIZE-1:0]             core_spk_out,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [LAYER_SIZE-1:0]             out_spk,
   output logic [LAYER_SIZE*COUNT_WIDTH-1:0] out_count,
   output logic [CW-1:0]                     out_class,
   output logic [SW-1:0]                     out_step,
   output logic                              err_done
);

   seq_state_t                                r_state;
   logic [SW-1:0]                             r_step;
   logic [LAYER_SIZE-1:0][COUNT_WIDTH-1:0]    r_cnt;
   logic [CW-1:0]                             r_idx;
   logic [CW-1:0]                             r_best_idx;
   logic [COUNT_WIDTH-1:0]                    r_best;
   logic [CW-1:0]                             r_class;
   logic [PRE_SYN_LAYER_SIZE-1:0]             r_core_in;
   logic [LAYER_SIZE-1:0]                     r_spk;
   logic [SW-1:0]                             r_ostep;
   logic                                      r_err;

   logic                                      w_full;
   logic                                      w_empty;
   logic                                      w_push;
   logic                                      w_pop;
   logic [PRE_SYN_LAYER_SIZE-1:0]             w_head;
   logic                                      w_last_step;
   logic                                      w_last_idx;
   logic                                      w_scan_gt;
   logic [CW-1:0]                             w_scan_idx;
   logic [COUNT_WIDTH-1:0]                    w_base;
   logic [LAYER_SIZE-1:0][COUNT_WIDTH-1:0]    w_cnt_next;

   assign w_push = in_valid && !w_full;
   assign w_pop  = (r_state == IDLE) && !w_empty;

   spk_fifo #(
      .WIDTH (PRE_SYN_LAYER_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (in_spk),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_last_step = (r_step == SW'(TIME_STEPS - 1));
   assign w_last_idx  = (r_idx == CW'(LAYER_SIZE - 1));
   assign w_scan_gt   = (r_cnt[r_idx] > r_best);
   assign w_scan_idx  = w_scan_gt ? r_idx : r_best_idx;

   // First step of a sample starts counting from zero; counts saturate.
   always_comb begin
      w_base     = '0;
      w_cnt_next = r_cnt;
      for (int i = 0; i < LAYER_SIZE; i++) begin
         w_base = (r_step == '0) ? '0 : r_cnt[i];
         w_cnt_next[i] = (core_spk_out[i] && (w_base != '1)) ?
                         w_base + 1'b1 : w_base;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_step     <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_best_idx <= '0;
         r_best     <= '0;
         r_class    <= '0;
         r_core_in  <= '0;
         r_spk      <= '0;
         r_ostep    <= '0;
         r_err      <= 1'b0;
      end else begin
         if (core_done && (r_state != WAIT)) r_err <= 1'b1;
         unique case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_core_in <= w_head;
                  r_state   <= START;
               end
            end
            START: r_state <= WAIT;
            WAIT: begin
               if (core_done) begin
                  r_spk   <= core_spk_out;
                  r_ostep <= r_step;
                  r_cnt   <= w_cnt_next;
                  if (OUT_MODE == MODE_SPIKE) begin
                     r_state <= OUTPUT;
                  end else if (!w_last_step) begin
                     r_step  <= r_step + 1'b1;
                     r_state <= IDLE;
                  end else if (OUT_MODE == MODE_ARGMAX) begin
                     r_idx      <= '0;
                     r_best     <= '0;
                     r_best_idx <= '0;
                     r_state    <= SCAN;
                  end else begin
                     r_state <= OUTPUT;
                  end
               end
            end
            // Strict compare keeps the lowest index on ties.
            SCAN: begin
               if (w_scan_gt) begin
                  r_best     <= r_cnt[r_idx];
                  r_best_idx <= r_idx;
               end
               r_idx <= r_idx + 1'b1;
               if (w_last_idx) begin
                  r_class <= w_scan_idx;
                  r_state <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  if (OUT_MODE == MODE_SPIKE)
                     r_step <= w_last_step ? '0 : r_step + 1'b1;
                  else
                     r_step <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = !w_full;
   assign core_start  = (r_state == START);
   assign core_clear  = core_start && (r_step == '0);
   assign core_spk_in = r_core_in;
   assign out_valid   = (r_state == OUTPUT);
   assign out_spk     = r_spk;
   assign out_count   = r_cnt;
   assign out_class   = (OUT_MODE == MODE_ARGMAX) ? r_class : '0;
   assign out_step    = r_ostep;
   assign err_done    = r_err;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Bench for snn_layer_sequencer: four instances (spike, count, argmax,
// count with 16 steps) against a push-order reference model.
module tb_snn_layer_sequencer;

   localparam int NI = 4;

   typedef struct {
      logic [3:0]  spk;
      int          step;
      logic [11:0] cnt;
      int          cls;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      logic [11:0] cnt;
      logic [3:0]  last;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid  [NI];
   logic        in_ready  [NI];
   logic [7:0]  in_spk    [NI];
   logic        c_start   [NI];
   logic        c_clear   [NI];
   logic [7:0]  c_in      [NI];
   logic        c_done    [NI];
   logic [3:0]  c_out     [NI];
   logic        f_done    [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];
   logic [3:0]  out_spk   [NI];
   logic [11:0] out_count [NI];
   logic [1:0]  out_class [NI];
   logic [3:0]  out_step  [NI];
   logic        err_done  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int TS = (g == 3) ? 16 : 4;
      localparam int SW = $clog2(TS);
      logic [SW-1:0] w_step;
      logic [2:0]    dly;

      snn_layer_sequencer #(
         .PRE_SYN_LAYER_SIZE (8),
         .LAYER_SIZE         (4),
         .TIME_STEPS         (TS),
         .FIFO_DEPTH         (4),
         .COUNT_WIDTH        (3),
         .OUT_MODE           ((g == 3) ? 1 : g)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid[g]),
         .in_ready     (in_ready[g]),
         .in_spk       (in_spk[g]),
         .core_start   (c_start[g]),
         .core_clear   (c_clear[g]),
         .core_spk_in  (c_in[g]),
         .core_done    (c_done[g]),
         .core_spk_out (c_out[g]),
         .out_valid    (out_valid[g]),
         .out_ready    (out_ready[g]),
         .out_spk      (out_spk[g]),
         .out_count    (out_count[g]),
         .out_class    (out_class[g]),
         .out_step     (w_step),
         .err_done     (err_done[g])
      );

      assign out_step[g] = 4'(w_step);

      // Core stand-in: done 3 cycles after start, spikes = upper nibble.
      always @(posedge clk or negedge rst) begin
         if (!rst) dly <= '0;
         else      dly <= {dly[1:0], c_start[g]};
      end
      assign c_done[g] = dly[2] | f_done[g];
      assign c_out[g]  = c_in[g][7:4];
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   function automatic int ts_of(input int g);
      return (g == 3) ? 16 : 4;
   endfunction

   function automatic int mode_of(input int g);
      return (g == 3) ? 1 : g;
   endfunction

   // Reference model: each accepted train is one time step of a sample.
   exp_t eq [NI][$];
   int   npush  [NI];
   int   nstart [NI];
   int   nacc   [NI];
   int   mc     [NI][4];

   task automatic model_push(input int g, input logic [7:0] d);
      exp_t e;
      int   st;
      int   b;
      st = npush[g] % ts_of(g);
      if (st == 0)
         for (int i = 0; i < 4; i++) mc[g][i] = 0;
      for (int i = 0; i < 4; i++)
         if (d[4+i] && mc[g][i] < 7) mc[g][i]++;
      if (mode_of(g) == 0 || st == ts_of(g) - 1) begin
         e.spk  = d[7:4];
         e.step = st;
         e.cnt  = '0;
         for (int i = 0; i < 4; i++) e.cnt[i*3 +: 3] = 3'(mc[g][i]);
         e.cls = 0;
         if (mode_of(g) == 2) begin
            b = 0;
            for (int i = 1; i < 4; i++)
               if (mc[g][i] > mc[g][b]) b = i;
            e.cls = b;
         end
         eq[g].push_back(e);
      end
      npush[g]++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int g = 0; g < NI; g++) begin
            eq[g].delete();
            npush[g]  = 0;
            nstart[g] = 0;
            for (int i = 0; i < 4; i++) mc[g][i] = 0;
         end
      end else begin
         for (int g = 0; g < NI; g++) begin
            if (in_valid[g] && in_ready[g]) model_push(g, in_spk[g]);
            if (c_start[g]) begin
               chk("core_clear", int'(c_clear[g]),
                   int'(nstart[g] % ts_of(g) == 0));
               nstart[g]++;
            end
            if (out_valid[g] && out_ready[g]) begin
               nacc[g]++;
               if (eq[g].size() == 0) begin
                  chk("unexpected_out", 1, 0);
               end else begin
                  e = eq[g].pop_front();
                  chk("sb_spk",   int'(out_spk[g]),   int'(e.spk));
                  chk("sb_step",  int'(out_step[g]),  e.step);
                  chk("sb_count", int'(out_count[g]), int'(e.cnt));
                  chk("sb_class", int'(out_class[g]), e.cls);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic push(input int g, input logic [7:0] d);
      int b;
      b = 0;
      in_valid[g] = 1'b1;
      in_spk[g]   = d;
      @(negedge clk);
      while (!in_ready[g] && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (!in_ready[g]) chk("push_timeout", 0, 1);
      tick();
   endtask

   task automatic lat_check(input int g, input int nd, input int exp,
                            input string nm);
      int dn;
      int j;
      dn = 0;
      j  = -1;
      for (int b = 0; b < 400; b++) begin
         @(negedge clk);
         if (j >= 0) j++;
         if (j > 0 && out_valid[g]) break;
         if (c_done[g]) begin
            dn++;
            if (dn == nd) j = 0;
         end
      end
      chk(nm, j, exp);
   endtask

   task automatic wait_valid(input int g, input string nm);
      int b;
      b = 0;
      @(negedge clk);
      while (!out_valid[g] && b < 1000) begin
         @(negedge clk);
         b++;
      end
      chk(nm, int'(out_valid[g]), 1);
   endtask

   task automatic accept(input int g);
      tick();
      out_ready[g] = 1'b1;
      tick();
      out_ready[g] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   vec_t vt [4];

   initial begin
      int base;
      logic held_low;

      vt[0] = '{32'hF3723110, 12'h29C, 4'hF};
      vt[1] = '{32'hF0F0F0F0, 12'h924, 4'hF};
      vt[2] = '{32'h0C0B0A09, 12'h000, 4'h0};
      vt[3] = '{32'h5AA55AA5, 12'h492, 4'h5};

      for (int g = 0; g < NI; g++) begin
         in_valid[g]  = 1'b0;
         in_spk[g]    = '0;
         out_ready[g] = 1'b0;
         f_done[g]    = 1'b0;
         nacc[g]      = 0;
      end

      repeat (3) tick();
      @(negedge clk);
      chk("rst_in_ready",  int'(in_ready[0]),  1);
      chk("rst_out_valid", int'(out_valid[0]), 0);
      chk("rst_start",     int'(c_start[0]),   0);
      chk("rst_core_in",   int'(c_in[0]),      0);
      chk("rst_count",     int'(out_count[1]), 0);
      chk("rst_err",       int'(err_done[0]),  0);
      tick();
      rst = 1'b1;
      tick();

      // Spike mode: single train, start latency and output fields.
      push(0, 8'hA5);
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("start_n1", int'(c_start[0]), 0);
      @(negedge clk);
      chk("start_n2", int'(c_start[0]), 1);
      chk("clear_n2", int'(c_clear[0]), 1);
      chk("core_in",  int'(c_in[0]),    8'hA5);
      lat_check(0, 1, 1, "lat_m0");
      chk("m0_spk",  int'(out_spk[0]),  4'hA);
      chk("m0_step", int'(out_step[0]), 0);
      accept(0);

      // Count mode: table of 4-step samples.
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 4; k++) push(1, vt[v].d[k*8 +: 8]);
         in_valid[1] = 1'b0;
         lat_check(1, 4, 1, "lat_m1");
         chk("tbl_count", int'(out_count[1]), int'(vt[v].cnt));
         chk("tbl_spk",   int'(out_spk[1]),   int'(vt[v].last));
         chk("tbl_step",  int'(out_step[1]),  3);
         accept(1);
         @(negedge clk);
         chk("tbl_single_valid", int'(out_valid[1]), 0);
         tick();
      end

      // Argmax mode: tie between n1/n2 goes to the lower index.
      push(2, 8'hF0);
      push(2, 8'h70);
      push(2, 8'h60);
      push(2, 8'h60);
      in_valid[2] = 1'b0;
      lat_check(2, 4, 5, "lat_m2");
      chk("m2_class", int'(out_class[2]), 1);
      chk("m2_count", int'(out_count[2]), 12'h322);
      accept(2);
      for (int k = 1; k <= 4; k++) push(2, 8'(k));
      in_valid[2] = 1'b0;
      lat_check(2, 4, 5, "lat_m2_zero");
      chk("m2_zero_class", int'(out_class[2]), 0);
      accept(2);

      // Backpressure: 4 buffered + 1 in core, sixth held off.
      base = nacc[0];
      for (int k = 1; k <= 5; k++) push(0, {4'(k), 4'h0});
      in_spk[0] = 8'h60;
      @(negedge clk);
      chk("bp_full", int'(in_ready[0]), 0);
      repeat (6) tick();
      @(negedge clk);
      chk("bp_still_full", int'(in_ready[0]), 0);
      chk("bp_out_held",   int'(out_valid[0]), 1);
      tick();
      out_ready[0] = 1'b1;
      push(0, 8'h60);
      in_valid[0] = 1'b0;
      for (int b = 0; b < 300 && eq[0].size() != 0; b++) tick();
      @(negedge clk);
      chk("bp_drained", nacc[0] - base, 6);
      tick();
      out_ready[0] = 1'b0;

      // Saturation: 16 steps, every neuron spikes, 3-bit counters.
      for (int k = 0; k < 16; k++) push(3, 8'hF0);
      in_valid[3] = 1'b0;
      wait_valid(3, "sat_valid");
      chk("sat_count", int'(out_count[3]), 12'hFFF);
      chk("sat_step",  int'(out_step[3]),  15);
      accept(3);

      // Random traffic on every instance against the model.
      for (int g = 0; g < NI; g++) begin
         for (int c = 0; c < 300; c++) begin
            in_valid[g]  = 1'($urandom_range(0, 1));
            in_spk[g]    = 8'($urandom);
            out_ready[g] = 1'($urandom_range(0, 1));
            tick();
         end
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b1;
         for (int b = 0; b < 2000 && eq[g].size() != 0; b++) tick();
         repeat (40) tick();
         @(negedge clk);
         chk("rnd_drained", eq[g].size(), 0);
         chk("rnd_no_extra", int'(out_valid[g]), 0);
         tick();
         out_ready[g] = 1'b0;
      end

      // Reset in the middle of a core wait.
      push(0, 8'hC3);
      in_valid[0] = 1'b0;
      for (int b = 0; b < 50 && !c_start[0]; b++) @(negedge clk);
      chk("pre_rst_start", int'(c_start[0]), 1);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_in_ready",  int'(in_ready[0]),  1);
      chk("arst_start",     int'(c_start[0]),   0);
      chk("arst_core_in",   int'(c_in[0]),      0);
      chk("arst_out_spk",   int'(out_spk[0]),   0);
      chk("arst_out_count", int'(out_count[0]), 0);
      chk("arst_out_valid", int'(out_valid[1]), 0);
      @(negedge clk);
      tick();
      rst = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      chk("post_rst_err",   int'(err_done[0]),  0);
      chk("post_rst_valid", int'(out_valid[0]), 0);
      tick();
      f_done[0] = 1'b1;
      tick();
      f_done[0] = 1'b0;
      held_low = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid[0] || c_start[0]) held_low = 1'b0;
      end
      chk("stray_err",      int'(err_done[0]), 1);
      chk("stray_no_valid", int'(held_low),    1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
